// File: rtl/coeff_bank_ram.sv
`default_nettype none
// ============================================================================
// Module   : coeff_bank_ram
// Brief    : Dual-port coefficient memory with a streaming load/unload engine.
//            Ports A/B serve random access while the sequencer is idle. A
//            sequencer writes a full polynomial from the s_* stream, or reads
//            it out to the m_* stream through a small skid FIFO.
//            Optional feature macro: COEFF_RAM_BITREV_EN (adds the bitrev
//            input for bit-reversed transfer order).
// Revision : 1.0 - initial release
// ============================================================================
module coeff_bank_ram #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [WIDTH-1:0]      din_a,
    output logic [WIDTH-1:0]      dout_a,
    output logic                  rvalid_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [WIDTH-1:0]      din_b,
    output logic [WIDTH-1:0]      dout_b,
    output logic                  rvalid_b,
    output logic                  collision,
    input  logic                  load_start,
    input  logic                  unload_start,
    input  logic                  s_valid,
    input  logic [WIDTH-1:0]      s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [WIDTH-1:0]      m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done
`ifdef COEFF_RAM_BITREV_EN
    ,
    input  logic                  bitrev
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_UNLOAD = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Skid FIFO holds every read that may be in flight when m_ready drops
    localparam int                    c_FIFO_DEPTH = READ_LAT + 1;
    localparam int                    c_FAW        = $clog2(c_FIFO_DEPTH);
    localparam int                    c_CW         = c_FAW + 1;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_s_ready;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] w_xaddr;

    logic                  w_idle, w_acc_a, w_acc_b, w_wr_a, w_wr_b, w_load_beat;
    logic [WIDTH-1:0]      r_dout_a1, r_dout_b1;
    logic                  r_rv_a1, r_rv_b1, r_collision;

    logic                  w_issue, w_push, w_pop, w_inflight;
    logic [WIDTH-1:0]      w_push_data;
    logic [WIDTH-1:0]      r_fifo [c_FIFO_DEPTH];
    logic [c_FAW-1:0]      r_wptr, r_rptr;
    logic [c_CW-1:0]       r_count, w_occ;

    // Random-access ports are only live while the sequencer is idle
    assign w_idle      = (r_state == ST_IDLE);
    assign w_acc_a     = en_a && w_idle;
    assign w_acc_b     = en_b && w_idle;
    assign w_wr_a      = w_acc_a && we_a;
    assign w_wr_b      = w_acc_b && we_b;
    assign w_load_beat = (r_state == ST_LOAD) && s_valid && r_s_ready;

`ifdef COEFF_RAM_BITREV_EN
    logic                  r_bitrev;
    logic [ADDR_WIDTH-1:0] w_cnt_rev;

    generate
        for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_rev
            assign w_cnt_rev[gi] = r_cnt[ADDR_WIDTH-1-gi];
        end
    endgenerate

    // Transfer order is latched once, when a transfer is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitrev <= 1'b0;
        end else if (w_idle && (load_start || unload_start)) begin
            r_bitrev <= bitrev;
        end
    end

    assign w_xaddr = r_bitrev ? w_cnt_rev : r_cnt;
`else
    assign w_xaddr = r_cnt;
`endif

    // Storage write: stream beats in LOAD; otherwise B then A, so A wins a tie
    always_ff @(posedge clk) begin
        if (w_load_beat) begin
            r_mem[w_xaddr] <= s_data;
        end else begin
            if (w_wr_b) r_mem[addr_b] <= din_b;
            if (w_wr_a) r_mem[addr_a] <= din_a;
        end
    end

    // First read stage: write-first on own port, old data across ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_a1   <= '0;
            r_dout_b1   <= '0;
            r_rv_a1     <= 1'b0;
            r_rv_b1     <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_rv_a1     <= w_acc_a;
            r_rv_b1     <= w_acc_b;
            r_collision <= w_wr_a && w_wr_b && (addr_a == addr_b);
            if (w_acc_a) r_dout_a1 <= we_a ? din_a : r_mem[addr_a];
            if (w_acc_b) r_dout_b1 <= we_b ? din_b : r_mem[addr_b];
        end
    end

    assign collision = r_collision;

    generate
        if (READ_LAT == 2) begin : g_port_lat2
            logic [WIDTH-1:0] r_dout_a2, r_dout_b2;
            logic             r_rv_a2, r_rv_b2;

            // Extra output register for the two-cycle read option
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout_a2 <= '0;
                    r_dout_b2 <= '0;
                    r_rv_a2   <= 1'b0;
                    r_rv_b2   <= 1'b0;
                end else begin
                    r_dout_a2 <= r_dout_a1;
                    r_dout_b2 <= r_dout_b1;
                    r_rv_a2   <= r_rv_a1;
                    r_rv_b2   <= r_rv_b1;
                end
            end

            assign dout_a   = r_dout_a2;
            assign dout_b   = r_dout_b2;
            assign rvalid_a = r_rv_a2;
            assign rvalid_b = r_rv_b2;
        end else begin : g_port_lat1
            assign dout_a   = r_dout_a1;
            assign dout_b   = r_dout_b1;
            assign rvalid_a = r_rv_a1;
            assign rvalid_b = r_rv_b1;
        end
    endgenerate

    // Reads are only issued when the FIFO is guaranteed room on arrival
    assign w_pop   = (r_count != '0) && m_ready;
    assign w_occ   = r_count + c_CW'(w_inflight);
    assign w_issue = (r_state == ST_UNLOAD) && (w_occ < c_CW'(c_FIFO_DEPTH));

    generate
        if (READ_LAT == 2) begin : g_ul_lat2
            logic             r_ul_v;
            logic [WIDTH-1:0] r_ul_d;

            // Unload read register ahead of the skid FIFO
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ul_v <= 1'b0;
                    r_ul_d <= '0;
                end else begin
                    r_ul_v <= w_issue;
                    if (w_issue) r_ul_d <= r_mem[w_xaddr];
                end
            end

            assign w_push      = r_ul_v;
            assign w_push_data = r_ul_d;
            assign w_inflight  = r_ul_v;
        end else begin : g_ul_lat1
            // The FIFO slot itself acts as the single read register
            assign w_push      = w_issue;
            assign w_push_data = r_mem[w_xaddr];
            assign w_inflight  = 1'b0;
        end
    endgenerate

    function automatic logic [c_FAW-1:0] f_ptr_inc(input logic [c_FAW-1:0] p);
        return (p == c_FAW'(c_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Output skid FIFO; entries cleared on reset so m_data starts at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < c_FIFO_DEPTH; i++) r_fifo[i] <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_push_data;
                r_wptr         <= f_ptr_inc(r_wptr);
            end
            if (w_pop) r_rptr <= f_ptr_inc(r_rptr);
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    assign m_valid = (r_count != '0);
    assign m_data  = r_fifo[r_rptr];

    // Sequencer: transfer control, beat counter and registered handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_s_ready <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load_start) begin
                        r_state   <= ST_LOAD;
                        r_s_ready <= 1'b1;
                        r_cnt     <= '0;
                    end else if (unload_start) begin
                        r_state <= ST_UNLOAD;
                        r_cnt   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_load_beat) begin
                        if (r_cnt == c_LAST_ADDR) begin
                            r_state   <= ST_IDLE;
                            r_s_ready <= 1'b0;
                            r_done    <= 1'b1;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_UNLOAD: begin
                    if (w_issue) begin
                        if (r_cnt == c_LAST_ADDR) r_state <= ST_DRAIN;
                        else                      r_cnt   <= r_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && (r_count == c_CW'(1)) && !w_push) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready = r_s_ready;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_coeff_bank_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_coeff_bank_ram
// Brief    : Self-checking bench for coeff_bank_ram against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coeff_bank_ram;

    localparam int W  = 32;
    localparam int D  = 256;
    localparam int AW = 8;
    localparam int RL = 1;

    logic          clk;
    logic          rst_n;
    logic          en_a, we_a, en_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [W-1:0]  din_a, din_b, dout_a, dout_b;
    logic          rvalid_a, rvalid_b, collision;
    logic          load_start, unload_start;
    logic          s_valid, s_ready, m_valid, m_ready, busy, done;
    logic [W-1:0]  s_data, m_data;
`ifdef COEFF_RAM_BITREV_EN
    logic          bitrev;
`endif

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [W-1:0]  model [D];
    logic [W-1:0]  got_q [$];

    coeff_bank_ram #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .READ_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a), .rvalid_a(rvalid_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b), .rvalid_b(rvalid_b),
        .collision(collision),
        .load_start(load_start), .unload_start(unload_start),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .done(done)
`ifdef COEFF_RAM_BITREV_EN
        , .bitrev(bitrev)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en_a = 0; we_a = 0; addr_a = '0; din_a = '0;
        en_b = 0; we_b = 0; addr_b = '0; din_b = '0;
        load_start = 0; unload_start = 0;
        s_valid = 0; s_data = '0; m_ready = 0;
`ifdef COEFF_RAM_BITREV_EN
        bitrev = 0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({dout_a, dout_b, m_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got dout_a=%h dout_b=%h m_data=%h required 0", dout_a, dout_b, m_data);
        end
        n_checks++;
        if ({rvalid_a, rvalid_b, collision, s_ready, m_valid, busy, done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {rvalid_a, rvalid_b, collision, s_ready, m_valid, busy, done});
        end
        rst_n = 1;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_load_seq();
        load_start = 1;
        tick();
        load_start = 0;
        n_checks++;
        if ({busy, s_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL load_start_busy: got busy,s_ready=%b required 11", {busy, s_ready});
        end
        s_valid = 1;
        for (int i = 0; i < D; i++) begin
            s_data = W'(i);
            tick();
            model[i] = W'(i);
            n_checks++;
            if (i < D - 1) begin
                if ({busy, s_ready, done} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL load_beat %0d: got busy,s_ready,done=%b required 110", i, {busy, s_ready, done});
                end
            end else if ({busy, s_ready, done} !== 3'b001) begin
                n_fail++;
                $display("FAIL load_last: got busy,s_ready,done=%b required 001", {busy, s_ready, done});
            end
        end
        s_valid = 0;
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done_pulse: got done=%b required 0", done);
        end
    endtask

    task automatic test_port_read();
        for (int t = 0; t < 6; t++) begin
            logic [AW-1:0] aa, ab;
            aa = (t == 0) ? AW'(17) : AW'($urandom_range(0, D - 1));
            ab = AW'($urandom_range(0, D - 1));
            en_a = 1; addr_a = aa; en_b = 1; addr_b = ab;
            tick();
            en_a = 0; en_b = 0;
            repeat (RL - 1) tick();
            n_checks++;
            if ({rvalid_a, rvalid_b} !== 2'b11 || dout_a !== model[aa] || dout_b !== model[ab]) begin
                n_fail++;
                $display("FAIL port_read a=%0d b=%0d: got rv=%b%b da=%h db=%h required 11 %h %h",
                         aa, ab, rvalid_a, rvalid_b, dout_a, dout_b, model[aa], model[ab]);
            end
            tick();
            n_checks++;
            if ({rvalid_a, rvalid_b} !== 2'b00) begin
                n_fail++;
                $display("FAIL port_rvalid_pulse: got %b%b required 00", rvalid_a, rvalid_b);
            end
        end
    endtask

    task automatic test_collision();
        en_a = 1; we_a = 1; addr_a = 5; din_a = 32'hAAAA;
        en_b = 1; we_b = 1; addr_b = 5; din_b = 32'h5555;
        tick();
        idle_inputs();
        model[5] = 32'hAAAA;
        n_checks++;
        if (collision !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_pulse: got %b required 1", collision);
        end
        tick();
        n_checks++;
        if (collision !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_width: got %b required 0", collision);
        end
        en_b = 1; addr_b = 5;
        tick();
        idle_inputs();
        repeat (RL - 1) tick();
        n_checks++;
        if (dout_b !== 32'hAAAA) begin
            n_fail++;
            $display("FAIL collision_winner: got %h required 0000aaaa", dout_b);
        end
    endtask

    task automatic test_cross_port();
        en_b = 1; we_b = 1; addr_b = 9; din_b = 32'h42;
        tick();
        en_a = 1; we_a = 1; addr_a = 9; din_a = 32'h1234;
        en_b = 1; we_b = 0; addr_b = 9;
        tick();
        idle_inputs();
        repeat (RL - 1) tick();
        model[9] = 32'h1234;
        n_checks++;
        if (dout_a !== 32'h1234 || dout_b !== 32'h42) begin
            n_fail++;
            $display("FAIL cross_port: got da=%h db=%h required 00001234 00000042", dout_a, dout_b);
        end
    endtask

    task automatic test_random_ports();
        localparam int N = 60;
        bit           eva [N], evb [N], ecol [N];
        logic [W-1:0] eda [N], edb [N];
        for (int k = 0; k <= N + RL; k++) begin
            int j;
            j = k - RL;
            if (j >= 0 && j < N) begin
                n_checks++;
                if (rvalid_a !== eva[j] || rvalid_b !== evb[j] ||
                    (eva[j] && dout_a !== eda[j]) || (evb[j] && dout_b !== edb[j])) begin
                    n_fail++;
                    $display("FAIL rand_ports cyc %0d: got rv=%b%b da=%h db=%h required rv=%b%b da=%h db=%h",
                             j, rvalid_a, rvalid_b, dout_a, dout_b, eva[j], evb[j], eda[j], edb[j]);
                end
            end
            if (k >= 1 && k - 1 < N) begin
                n_checks++;
                if (collision !== ecol[k-1]) begin
                    n_fail++;
                    $display("FAIL rand_collision cyc %0d: got %b required %b", k - 1, collision, ecol[k-1]);
                end
            end
            if (k < N) begin
                en_a = ($urandom_range(0, 3) != 0); we_a = 1'($urandom_range(0, 1));
                addr_a = AW'($urandom_range(0, 7)); din_a = $urandom;
                en_b = ($urandom_range(0, 3) != 0); we_b = 1'($urandom_range(0, 1));
                addr_b = AW'($urandom_range(0, 7)); din_b = $urandom;
                eva[k]  = en_a;
                evb[k]  = en_b;
                eda[k]  = we_a ? din_a : model[addr_a];
                edb[k]  = we_b ? din_b : model[addr_b];
                ecol[k] = en_a && we_a && en_b && we_b && (addr_a == addr_b);
                if (en_b && we_b) model[addr_b] = din_b;
                if (en_a && we_a) model[addr_a] = din_a;
            end else begin
                idle_inputs();
            end
            tick();
        end
        idle_inputs();
    endtask

    // Drives one unload and collects popped beats; mode 0 ready, 1 toggle, 2 random
    task automatic do_unload(input int mode, input bit abuse, output int done_cyc,
                             output int first_v, output int unstable, output int abuse_viol);
        bit           hold;
        logic [W-1:0] prev;
        int           tog;
        got_q.delete();
        done_cyc = -1; first_v = -1; unstable = 0; abuse_viol = 0;
        hold = 0; prev = '0; tog = 0;
        unload_start = 1;
        tick();
        unload_start = 0;
        if (abuse) begin
            en_a = 1; we_a = 1; addr_a = 3; din_a = 32'hDEADBEEF;
            en_b = 1; we_b = 1; addr_b = 3; din_b = 32'hBADC0DE5;
            load_start = 1;
        end
        for (int k = 1; k < 4000; k++) begin
            if (abuse && (rvalid_a || rvalid_b || collision)) abuse_viol++;
            if (done) begin
                done_cyc = k;
                break;
            end
            if (m_valid) begin
                if (first_v < 0) first_v = k;
                if (hold && m_data !== prev) unstable++;
            end
            case (mode)
                0:       m_ready = 1;
                1:       begin m_ready = (tog % 2 == 0); tog++; end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (m_valid && m_ready) got_q.push_back(m_data);
            hold = m_valid && !m_ready;
            prev = m_data;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_unload_full();
        int dc, fv, us, av;
        do_unload(0, 0, dc, fv, us, av);
        n_checks++;
        if (fv !== 1 + RL) begin
            n_fail++;
            $display("FAIL unload_first_valid: got cycle %0d required %0d", fv, 1 + RL);
        end
        n_checks++;
        if (dc !== D + RL + 1) begin
            n_fail++;
            $display("FAIL unload_done_cycle: got %0d required %0d", dc, D + RL + 1);
        end
        n_checks++;
        if (got_q.size() !== D) begin
            n_fail++;
            $display("FAIL unload_full_count: got %0d required %0d", got_q.size(), D);
        end
        for (int i = 0; i < D && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== model[i]) begin
                n_fail++;
                $display("FAIL unload_full_data %0d: got %h required %h", i, got_q[i], model[i]);
            end
        end
    endtask

    task automatic test_unload_toggle();
        int dc, fv, us, av;
        do_unload(1, 1, dc, fv, us, av);
        n_checks++;
        if (dc < 0 || us !== 0 || av !== 0) begin
            n_fail++;
            $display("FAIL unload_toggle: got done_cyc=%0d unstable=%0d busy_access=%0d required >0,0,0", dc, us, av);
        end
        n_checks++;
        if (got_q.size() !== D) begin
            n_fail++;
            $display("FAIL unload_toggle_count: got %0d required %0d", got_q.size(), D);
        end
        for (int i = 0; i < D && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== model[i]) begin
                n_fail++;
                $display("FAIL unload_toggle_data %0d: got %h required %h", i, got_q[i], model[i]);
            end
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored_while_busy: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_load_random();
        int beats, bad, dc;
        beats = 0; bad = 0; dc = -1;
        load_start = 1;
        tick();
        load_start = 0;
        for (int k = 1; k < 3000; k++) begin
            if (done) begin
                dc = k;
                break;
            end
            if (!(busy && s_ready)) bad++;
            s_valid      = 1'($urandom_range(0, 1));
            s_data       = $urandom;
            unload_start = 1'($urandom_range(0, 1));
            if (s_valid) begin
                model[beats] = s_data;
                beats++;
            end
            tick();
        end
        idle_inputs();
        n_checks++;
        if (dc < 0 || beats !== D || bad !== 0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_random: got done_cyc=%0d beats=%0d not_ready=%0d s_ready=%b required >0,%0d,0,0",
                     dc, beats, bad, s_ready, D);
        end
    endtask

    task automatic test_unload_random();
        int dc, fv, us, av;
        do_unload(2, 0, dc, fv, us, av);
        n_checks++;
        if (dc < 0 || us !== 0 || got_q.size() !== D) begin
            n_fail++;
            $display("FAIL unload_random: got done_cyc=%0d unstable=%0d count=%0d required >0,0,%0d",
                     dc, us, got_q.size(), D);
        end
        for (int i = 0; i < D && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== model[i]) begin
                n_fail++;
                $display("FAIL unload_random_data %0d: got %h required %h", i, got_q[i], model[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pops, dc, fv, us, av;
        pops = 0;
        unload_start = 1;
        tick();
        unload_start = 0;
        m_ready = 1;
        for (int k = 0; k < 1000 && pops < 100; k++) begin
            if (m_valid) pops++;
            tick();
        end
        #2;
        rst_n = 0;
        #1;
        n_checks++;
        if ({m_valid, busy, done} !== 3'b000 || m_data !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got m_valid,busy,done=%b m_data=%h after %0d pops required 000 0",
                     {m_valid, busy, done}, m_data, pops);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1;
        tick();
        do_unload(0, 0, dc, fv, us, av);
        n_checks++;
        if (dc !== D + RL + 1 || got_q.size() !== D) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got done_cyc=%0d count=%0d required %0d %0d",
                     dc, got_q.size(), D + RL + 1, D);
        end
        for (int i = 0; i < D && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== model[i]) begin
                n_fail++;
                $display("FAIL reset_mid_data %0d: got %h required %h", i, got_q[i], model[i]);
            end
        end
    endtask

`ifdef COEFF_RAM_BITREV_EN
    function automatic int rev_idx(input int x);
        int r;
        r = 0;
        for (int b = 0; b < AW; b++) r = r * 2 + ((x >> b) & 1);
        return r;
    endfunction

    task automatic test_bitrev();
        int dc, fv, us, av;
        bitrev = 1;
        unload_start = 1;
        tick();
        unload_start = 0;
        bitrev = 0;
        // first transfer already accepted above; finish it by draining
        m_ready = 1;
        got_q.delete();
        for (int k = 0; k < 4000 && !done; k++) begin
            if (m_valid) got_q.push_back(m_data);
            tick();
        end
        m_ready = 0;
        dc = 0; fv = 0; us = 0; av = 0;
        n_checks++;
        if (got_q.size() !== D) begin
            n_fail++;
            $display("FAIL bitrev_count: got %0d required %0d", got_q.size(), D);
        end
        for (int i = 0; i < D && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== model[rev_idx(i)]) begin
                n_fail++;
                $display("FAIL bitrev_data %0d: got %h required %h", i, got_q[i], model[rev_idx(i)]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_seq();
        test_port_read();
        test_collision();
        test_cross_port();
        test_random_ports();
        test_unload_full();
        test_unload_toggle();
        test_load_random();
        test_unload_random();
        test_reset_mid();
`ifdef COEFF_RAM_BITREV_EN
        test_bitrev();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
